ir_word_encoder: RTL and testbench
==================================

# ir_word_encoder

Instruction-word encoder and issue buffer feeding the core's 32-bit instruction register. Accepts instruction fields (opcode, register indices, immediate) from a program loader or sequencer over a valid/ready handshake and packs them into the core's IR field layout. Buffers the packed words in a small FIFO and presents them to the core's IR load port over a second valid/ready handshake. It is the producer of the words that the core's decode and execute logic consumes.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- NUM_OPS, 12: number of legal opcodes, 0..NUM_OPS-1. Used only when the legality check is compiled in.

- clk  in  1  rising-edge clock
- sys_rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  field set present
- in_ready  out  1  encoder can accept (= not full)
- in_oper  in  5  oper_type
- in_rdst  in  5  destination GPR index
- in_rsrc1  in  5  source-1 GPR index
- in_rsrc2  in  5  source-2 GPR index (register mode only)
- in_imm_mode  in  1  1 = immediate form
- in_imm  in  16  immediate (immediate mode only)
- ir_valid  out  1  ir_word holds a valid instruction (= not empty)
- ir_ready  in  1  core loads ir_word this cycle
- ir_word  out  32  packed instruction at FIFO head
- issued_cnt  out  16  count of completed ir handshakes
- err_illegal  out  1  one-cycle pulse: illegal opcode dropped
- err_cnt  out  8  saturating count of dropped words

## Operation
- Packing:
  - IR[31:27] = in_oper
  - IR[26:22] = in_rdst
  - IR[21:17] = in_rsrc1
  - IR[16] = in_imm_mode
  - Immediate mode: IR[15:0] = in_imm; in_rsrc2 ignored.
  - Register mode: IR[15:11] = in_rsrc2; IR[10:0] = 0; in_imm ignored.
- Push: fires when in_valid && in_ready and the word is legal. The word is written at the tail pointer, and the tail pointer and count increment.
- Pop: fires when ir_valid && ir_ready. The head pointer increments, the count decrements, and issued_cnt increments, wrapping at 16 bits.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count == DEPTH): in_ready = 0. No push, even if a pop occurs in the same cycle; no pass-through.
- Empty: ir_valid = 0 and ir_word holds its last value. No bypass; a word pushed into an empty FIFO appears the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- ir_word is read combinationally from the FIFO memory at the head pointer.

## Timing
- Reset (sys_rst_n low at a rising edge):
  - Clears the pointers, count, issued_cnt and err_cnt.
  - Outputs: in_ready = 1, ir_valid = 0, ir_word = 0, issued_cnt = 0, err_illegal = 0, err_cnt = 0.
  - FIFO contents are discarded, including in-flight words.
- Latency: a word accepted at edge N is valid on ir_word with ir_valid = 1 after edge N, and can be popped at edge N+1 at the earliest.
- in_ready and ir_valid depend only on registered count, never combinationally on in_valid or ir_ready.
- Once ir_valid is high, ir_word is stable until the pop edge.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- IR_ENC_CHECK_EN defined:
  - An accepted field set with in_oper >= NUM_OPS completes the input handshake but is not written to the FIFO.
  - err_illegal pulses high for the cycle after acceptance.
  - err_cnt increments, saturating at 255.
- IR_ENC_CHECK_EN undefined:
  - Every accepted field set is packed and pushed unchanged.
  - err_illegal and err_cnt are tied to 0.

## Test plan
- ADDI, oper=2, rdst=0, rsrc1=2, imm_mode=1, imm=4 -> ir_word = 0x10050004 one cycle after acceptance; issued_cnt = 1 after pop.
- ADD, oper=2, rdst=0, rsrc1=4, rsrc2=5, imm_mode=0, in_imm=0xFFFF -> ir_word = 0x10082800 (imm ignored, IR[10:0] = 0).
- Push in order MOVI (oper=1, rdst=4, imm=55), ANDI (oper=6, rdst=4, rsrc1=7, imm=56), XORI (oper=7, same fields) with ir_ready low -> count = 3. Then hold ir_ready high -> pops 0x09010037, 0x310F0038, 0x390F0038 in order on consecutive cycles.
- Fill DEPTH=4 with ir_ready=0 -> in_ready = 0 after the 4th push. Assert a 5th in_valid with ir_ready=1 in the same cycle -> one pop, no push; in_ready = 1 on the next cycle. With in_valid and ir_ready held high at count=2 for 10 cycles -> count remains 2.
- With IR_ENC_CHECK_EN, push oper=12 -> no ir_valid, err_illegal pulses once, err_cnt = 1. Push it 300 times -> err_cnt = 255. Without the macro: ir_word = 0x60000000 and err_cnt stays 0.
- Drop sys_rst_n for one edge with count = 3 -> ir_valid = 0, in_ready = 1, issued_cnt = 0; the next push appears alone.

Source files
------------

// File: rtl/ir_word_encoder.sv
// rtl/ir_word_encoder.sv - packs instruction fields into IR words and buffers them for the core's IR load port
// Optional opcode legality check: define IR_ENC_CHECK_EN.
module ir_word_encoder #(
   parameter int DEPTH   = 4,
   parameter int NUM_OPS = 12
) (
   input  logic        clk,
   input  logic        sys_rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_oper,
   input  logic [4:0]  in_rdst,
   input  logic [4:0]  in_rsrc1,
   input  logic [4:0]  in_rsrc2,
   input  logic        in_imm_mode,
   input  logic [15:0] in_imm,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [31:0] ir_word,
   output logic [15:0] issued_cnt,
   output logic        err_illegal,
   output logic [7:0]  err_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [5:0]    OP_LIMIT = 6'(NUM_OPS);

`ifdef IR_ENC_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic [31:0]   last_word;
   logic [31:0]   packed_word;
   logic          legal;
   logic          accept;
   logic          push;
   logic          pop;
   logic          drop;

   assign in_ready = (count != CNT_FULL);
   assign ir_valid = (count != '0);

   // When empty the last popped word is shown so ir_word never drifts to stale slots.
   assign ir_word = ir_valid ? mem[head] : last_word;

   always_comb begin
      packed_word = {in_oper, in_rdst, in_rsrc1, in_imm_mode, 16'h0000};
      if (in_imm_mode)
         packed_word[15:0] = in_imm;
      else
         packed_word[15:11] = in_rsrc2;
   end

   assign legal  = !CHECK_EN || ({1'b0, in_oper} < OP_LIMIT);
   assign accept = in_valid && in_ready;
   assign push   = accept && legal;
   assign drop   = accept && !legal;
   assign pop    = ir_valid && ir_ready;

   always_ff @(posedge clk) begin
      if (push)
         mem[tail] <= packed_word;
   end

   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         last_word   <= '0;
         issued_cnt  <= '0;
         err_illegal <= 1'b0;
         err_cnt     <= '0;
      end else begin
         if (push)
            tail <= tail + PTR_ONE;
         if (pop) begin
            head       <= head + PTR_ONE;
            last_word  <= mem[head];
            issued_cnt <= issued_cnt + 16'd1;
         end
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (pop && !push)
            count <= count - CNT_ONE;
         err_illegal <= drop;
         if (drop && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ir_word_encoder.sv
// tb/tb_ir_word_encoder.sv - directed self-checking bench for ir_word_encoder
module tb_ir_word_encoder;

   logic        clk = 1'b0;
   logic        sys_rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_oper;
   logic [4:0]  in_rdst;
   logic [4:0]  in_rsrc1;
   logic [4:0]  in_rsrc2;
   logic        in_imm_mode;
   logic [15:0] in_imm;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir_word;
   logic [15:0] issued_cnt;
   logic        err_illegal;
   logic [7:0]  err_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ir_word_encoder #(.DEPTH(4), .NUM_OPS(12)) dut (
      .clk         (clk),
      .sys_rst_n   (sys_rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_oper     (in_oper),
      .in_rdst     (in_rdst),
      .in_rsrc1    (in_rsrc1),
      .in_rsrc2    (in_rsrc2),
      .in_imm_mode (in_imm_mode),
      .in_imm      (in_imm),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready),
      .ir_word     (ir_word),
      .issued_cnt  (issued_cnt),
      .err_illegal (err_illegal),
      .err_cnt     (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic mode, input logic [15:0] imm);
      in_oper     = op;
      in_rdst     = rd;
      in_rsrc1    = rs1;
      in_rsrc2    = rs2;
      in_imm_mode = mode;
      in_imm      = imm;
   endtask

   task automatic push_one(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic mode, input logic [15:0] imm);
      set_fields(op, rd, rs1, rs2, mode, imm);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // Register-mode word with oper/rdst chosen by the caller, other fields zero
   function automatic logic [31:0] reg_word(input logic [4:0] op, input logic [4:0] rd);
      return (32'(op) << 27) | (32'(rd) << 22);
   endfunction

   logic [31:0] q[$];
   int pops;

   initial begin
      sys_rst_n = 1'b0;
      in_valid  = 1'b0;
      ir_ready  = 1'b0;
      set_fields(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
      step();
      step();
      sys_rst_n = 1'b1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_ir_valid", 32'(ir_valid), 32'd0);
      check("rst_ir_word", ir_word, 32'h0);
      check("rst_issued", 32'(issued_cnt), 32'd0);
      check("rst_err_illegal", 32'(err_illegal), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);

      // ADDI
      push_one(5'd2, 5'd0, 5'd2, 5'd0, 1'b1, 16'd4);
      check("addi_valid", 32'(ir_valid), 32'd1);
      check("addi_word", ir_word, 32'h10050004);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      check("addi_issued", 32'(issued_cnt), 32'd1);
      check("addi_empty", 32'(ir_valid), 32'd0);
      check("empty_hold", ir_word, 32'h10050004);

      // ADD, immediate ignored
      push_one(5'd2, 5'd0, 5'd4, 5'd5, 1'b0, 16'hFFFF);
      check("add_word", ir_word, 32'h10082800);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;

      // MOVI / ANDI / XORI queued then drained back to back
      push_one(5'd1, 5'd4, 5'd0, 5'd0, 1'b1, 16'd55);
      push_one(5'd6, 5'd4, 5'd7, 5'd0, 1'b1, 16'd56);
      push_one(5'd7, 5'd4, 5'd7, 5'd0, 1'b1, 16'd56);
      check("three_in_ready", 32'(in_ready), 32'd1);
      ir_ready = 1'b1;
      check("pop_movi", ir_word, 32'h09010037);
      step();
      check("pop_andi", ir_word, 32'h310F0038);
      step();
      check("pop_xori", ir_word, 32'h390F0038);
      step();
      ir_ready = 1'b0;
      check("three_drained", 32'(ir_valid), 32'd0);
      check("issued_5", 32'(issued_cnt), 32'd5);

      // Fill to DEPTH, then pop with a blocked push in the same cycle
      for (int k = 1; k <= 4; k++)
         push_one(5'(k), 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
      check("full_in_ready", 32'(in_ready), 32'd0);
      set_fields(5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
      in_valid = 1'b1;
      ir_ready = 1'b1;
      check("full_head", ir_word, reg_word(5'd1, 5'd0));
      step();
      in_valid = 1'b0;
      check("after_full_in_ready", 32'(in_ready), 32'd1);
      for (int k = 2; k <= 4; k++) begin
         check($sformatf("full_drain_%0d", k), ir_word, reg_word(5'(k), 5'd0));
         step();
      end
      ir_ready = 1'b0;
      check("full_no_fifth", 32'(ir_valid), 32'd0);

      // Sustained push+pop at count 2
      q.delete();
      for (int k = 0; k < 2; k++) begin
         q.push_back(reg_word(5'd3, 5'(k)));
         push_one(5'd3, 5'(k), 5'd0, 5'd0, 1'b0, 16'h0);
      end
      in_valid = 1'b1;
      ir_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_fields(5'd3, 5'(i + 2), 5'd0, 5'd0, 1'b0, 16'h0);
         if (i == 0 || i == 9)
            check($sformatf("steady_word_%0d", i), ir_word, q[0]);
         else if (ir_word !== q[0])
            check($sformatf("steady_word_%0d", i), ir_word, q[0]);
         q.push_back(reg_word(5'd3, 5'(i + 2)));
         void'(q.pop_front());
         step();
      end
      in_valid = 1'b0;
      pops = 0;
      for (int i = 0; i < 8 && ir_valid; i++) begin
         pops++;
         step();
      end
      ir_ready = 1'b0;
      check("steady_count", 32'(pops), 32'd2);
      check("issued_21", 32'(issued_cnt), 32'd21);

`ifdef IR_ENC_CHECK_EN
      push_one(5'd12, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
      check("illegal_no_valid", 32'(ir_valid), 32'd0);
      check("illegal_pulse", 32'(err_illegal), 32'd1);
      check("illegal_cnt1", 32'(err_cnt), 32'd1);
      step();
      check("illegal_pulse_end", 32'(err_illegal), 32'd0);
      set_fields(5'd12, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++)
         step();
      in_valid = 1'b0;
      check("illegal_sat", 32'(err_cnt), 32'd255);
`else
      push_one(5'd12, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
      check("op12_word", ir_word, 32'h60000000);
      check("op12_err_cnt", 32'(err_cnt), 32'd0);
      check("op12_err_pulse", 32'(err_illegal), 32'd0);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
`endif

      // Reset with three words in flight
      for (int k = 0; k < 3; k++)
         push_one(5'd9, 5'(k), 5'd0, 5'd0, 1'b0, 16'h0);
      sys_rst_n = 1'b0;
      step();
      sys_rst_n = 1'b1;
      check("rst2_ir_valid", 32'(ir_valid), 32'd0);
      check("rst2_in_ready", 32'(in_ready), 32'd1);
      check("rst2_issued", 32'(issued_cnt), 32'd0);
      check("rst2_ir_word", ir_word, 32'h0);
      push_one(5'd10, 5'd3, 5'd1, 5'd2, 1'b0, 16'h0);
      check("rst2_new_word", ir_word, 32'h50C21000);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      check("rst2_alone", 32'(ir_valid), 32'd0);
      check("rst2_issued1", 32'(issued_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
